// File: rtl/dma_channel_sequencer_pkg.sv
// Shared types and constants for the DMA channel sequencer: FSM states,
// command-register bit positions and transfer-mode encodings.
package dma_pkg;

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4} state_t;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  localparam logic [1:0] MODE_DEMAND = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_BLOCK  = 2'b10;

  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_channel_sequencer_if.sv
// Bus-side handshake bundle of the sequencer: DREQ/HOLD handshake in,
// strobes, acknowledges and register-update pulses out.
interface dma_channel_sequencer_if;
  logic [3:0] dreq;
  logic       hlda;
  logic       tc;
  logic       eop_n;
  logic       hrq;
  logic [3:0] dack;
  logic       aen;
  logic       adstb;
  logic       rd_strobe;
  logic       wr_strobe;
  logic       xfer_strobe;
  logic [1:0] active_ch;
  logic [3:0] tc_mask_set;
  logic [3:0] req_clr;

  modport master (
    input  dreq, hlda, tc, eop_n,
    output hrq, dack, aen, adstb, rd_strobe, wr_strobe, xfer_strobe,
           active_ch, tc_mask_set, req_clr
  );

  modport slave (
    output dreq, hlda, tc, eop_n,
    input  hrq, dack, aen, adstb, rd_strobe, wr_strobe, xfer_strobe,
           active_ch, tc_mask_set, req_clr
  );
endinterface

// File: rtl/dma_channel_sequencer_priority.sv
// Combinational channel arbiter: fixed order from ch0, or rotating order
// starting at prio_ptr.
module dma_priority_encoder (
  input  logic [3:0] eff,
  input  logic [1:0] prio_ptr,
  input  logic       rotate,
  output logic [1:0] winner,
  output logic       any_req
);

  logic [1:0] base;
  logic [1:0] idx;

  // Walk from lowest to highest priority so the highest requester is written last.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |eff;
    base    = rotate ? prio_ptr : 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (eff[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/dma_channel_sequencer.sv
// Timing and arbitration controller for the 4-channel DMA: request
// qualification, HRQ/HLDA handshake and the S0..S4 transfer sequence.
import dma_pkg::*;

module dma_channel_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               command_reg,
  input  logic [7:0]               mode_reg,
  input  logic [3:0]               mask_reg,
  input  logic [3:0]               request_reg,
  dma_channel_sequencer_if.master  bus
);

  localparam logic [1:0] WAIT_LAST = 2'(WAIT_STATES);

  state_t     state, next_state;
  logic [1:0] active_ch_q, next_ch;
  logic [1:0] prio_ptr, next_ptr;
  logic [1:0] wait_cnt, next_wait;
  logic [3:0] eff;
  logic [3:0] grant;
  logic [1:0] winner;
  logic       any_req;
  logic       disabled;
  logic       terminate;
  logic       continue_burst;
  logic [1:0] mode;
  logic       unused_bits;

  assign unused_bits = ^{command_reg[5], command_reg[3], command_reg[1:0], mode_reg[5:0]};
  assign disabled    = command_reg[CMD_DISABLE];
  assign mode        = mode_reg[7:6];
  assign terminate   = bus.tc | ~bus.eop_n;

  always_comb begin
    eff = '0;
    for (int i = 0; i < NUM_CH; i++)
      eff[i] = ((bus.dreq[i] ^ command_reg[CMD_DREQ_LOW]) & ~mask_reg[i]) | request_reg[i];
  end

  // Reserved mode 11 falls out as single because it is neither block nor demand.
  assign continue_burst = !disabled && !terminate &&
                          ((mode == MODE_BLOCK) || (mode == MODE_DEMAND && eff[active_ch_q]));

  dma_priority_encoder u_prio (
    .eff      (eff),
    .prio_ptr (prio_ptr),
    .rotate   (command_reg[CMD_ROTATE]),
    .winner   (winner),
    .any_req  (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      active_ch_q <= '0;
      prio_ptr    <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= next_state;
      active_ch_q <= next_ch;
      prio_ptr    <= next_ptr;
      wait_cnt    <= next_wait;
    end
  end

  // Losing HLDA anywhere past S0 abandons the word without touching prio_ptr.
  always_comb begin
    next_state = state;
    next_ch    = active_ch_q;
    next_ptr   = prio_ptr;
    next_wait  = wait_cnt;
    case (state)
      IDLE: if (!disabled && any_req) next_state = S0;
      S0: begin
        if (bus.hlda) begin
          if (any_req) begin
            next_state = S1;
            next_ch    = winner;
          end else begin
            next_state = IDLE;
          end
        end
      end
      S1: next_state = bus.hlda ? S2 : IDLE;
      S2: begin
        next_state = bus.hlda ? S3 : IDLE;
        next_wait  = '0;
      end
      S3: begin
        if (!bus.hlda)                  next_state = IDLE;
        else if (wait_cnt == WAIT_LAST) next_state = S4;
        else                            next_wait  = wait_cnt + 2'd1;
      end
      S4: begin
        if (!bus.hlda) begin
          next_state = IDLE;
        end else if (continue_burst) begin
          next_state = S2;
        end else begin
          next_state = IDLE;
          next_ptr   = active_ch_q + 2'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant           = '0;
    bus.hrq         = (state != IDLE);
    bus.aen         = (state == S1) || (state == S2) || (state == S3) || (state == S4);
    bus.adstb       = (state == S1);
    bus.rd_strobe   = (state == S2);
    bus.wr_strobe   = (state == S3);
    bus.xfer_strobe = (state == S4) && bus.hlda;
    bus.active_ch   = active_ch_q;
    bus.tc_mask_set = '0;
    bus.req_clr     = '0;
    if (state == S2 || state == S3 || state == S4) grant = ch_onehot(active_ch_q);
    if (state == S4 && bus.hlda && terminate) begin
      bus.tc_mask_set = ch_onehot(active_ch_q);
      bus.req_clr     = ch_onehot(active_ch_q);
    end
    bus.dack = command_reg[CMD_DACK_HIGH] ? grant : ~grant;
  end

endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Self-checking bench for dma_channel_sequencer: a scoreboard of expected
// words is filled as requests are raised and drained on each xfer_strobe.
module tb_dma_channel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] commandReg;
  logic [7:0] modeReg;
  logic [3:0] maskReg;
  logic [3:0] requestReg;

  dma_channel_sequencer_if bus();

  dma_channel_sequencer #(.NUM_CH(4), .WAIT_STATES(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .command_reg (commandReg),
    .mode_reg    (modeReg),
    .mask_reg    (maskReg),
    .request_reg (requestReg),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] dack;
    logic [3:0] tcMask;
    logic [3:0] reqClr;
  } xfer_t;

  xfer_t expQ[$];
  xfer_t expHead;
  int    errorCount = 0;
  int    checkCount = 0;
  int    xferSeen   = 0;
  bit    autoHlda   = 1'b0;
  int    cyc;
  int    startSeen;
  int    hrqCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] mode,
                               input logic [3:0] mask, input logic [3:0] req, input logic [3:0] dreq);
    commandReg = cmd;
    modeReg    = mode;
    maskReg    = mask;
    requestReg = req;
    bus.dreq   = dreq;
  endtask

  task automatic expectXfer(input logic [1:0] ch, input logic [3:0] tcMask, input logic [3:0] reqClr);
    xfer_t e;
    logic [3:0] oh;
    oh       = 4'b0001 << ch;
    e.ch     = ch;
    e.dack   = commandReg[7] ? oh : ~oh;
    e.tcMask = tcMask;
    e.reqClr = reqClr;
    expQ.push_back(e);
  endtask

  task automatic waitXfer(input string tag, output int cycles);
    int start;
    start  = xferSeen;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (xferSeen == start && cycles < 40);
    if (xferSeen == start) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic applyReset();
    rst_n    = 1'b0;
    autoHlda = 1'b0;
    bus.hlda = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Behaves like the CPU granting the bus one cycle after each hold request.
  always @(posedge clk) begin
    #2;
    if (autoHlda) bus.hlda = bus.hrq;
  end

  always @(negedge clk) begin
    if (rst_n && bus.xfer_strobe) begin
      xferSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_xfer", 32'd1, 32'd0);
      end else begin
        expHead = expQ.pop_front();
        checkOutput("xfer_word",
                    32'({bus.active_ch, bus.dack, bus.tc_mask_set, bus.req_clr}),
                    32'(expHead));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(8'h00, 8'h40, 4'h0, 4'h0, 4'h0);
    bus.hlda  = 1'b0;
    bus.tc    = 1'b0;
    bus.eop_n = 1'b1;
    #3;
    checkOutput("reset_ctrl",
                32'({bus.hrq, bus.aen, bus.adstb, bus.rd_strobe, bus.wr_strobe, bus.xfer_strobe,
                     bus.active_ch, bus.tc_mask_set, bus.req_clr}), 32'd0);
    checkOutput("reset_dack_low", 32'(bus.dack), 32'hF);
    commandReg = 8'h80;
    #1;
    checkOutput("reset_dack_high", 32'(bus.dack), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single mode ch2 with a manually delayed HLDA.
    applyStimulus(8'h80, 8'h40, 4'h0, 4'h0, 4'b0100);
    expectXfer(2'd2, 4'h0, 4'h0);
    tick();
    checkOutput("t1_hrq_rise", 32'({bus.hrq, bus.adstb}), 32'b10);
    tick();
    tick();
    bus.hlda = 1'b1;
    tick();
    checkOutput("t1_s1", 32'({bus.adstb, bus.aen, bus.active_ch, bus.dack}), 32'({1'b1, 1'b1, 2'd2, 4'b0000}));
    bus.dreq = 4'h0;
    tick();
    checkOutput("t1_s2", 32'({bus.adstb, bus.rd_strobe, bus.wr_strobe, bus.dack}), 32'({3'b010, 4'b0100}));
    tick();
    checkOutput("t1_s3", 32'({bus.rd_strobe, bus.wr_strobe, bus.dack}), 32'({2'b01, 4'b0100}));
    tick();
    tick();
    checkOutput("t1_release", 32'({bus.hrq, bus.aen, bus.dack}), 32'({2'b00, 4'b0000}));
    checkOutput("t1_count", 32'(xferSeen), 32'd1);
    bus.hlda = 1'b0;

    // Fixed priority: ch1 beats ch3.
    autoHlda = 1'b1;
    applyStimulus(8'h80, 8'h40, 4'h0, 4'h0, 4'b1010);
    expectXfer(2'd1, 4'h0, 4'h0);
    waitXfer("t2_first", cyc);
    bus.dreq = 4'b1000;
    expectXfer(2'd3, 4'h0, 4'h0);
    waitXfer("t2_second", cyc);
    bus.dreq = 4'h0;
    tick();

    // Rotating priority from a fresh pointer.
    applyReset();
    autoHlda = 1'b1;
    applyStimulus(8'h90, 8'h40, 4'h0, 4'h0, 4'b1010);
    expectXfer(2'd1, 4'h0, 4'h0);
    waitXfer("t3_ch1", cyc);
    bus.dreq = 4'b1011;
    expectXfer(2'd3, 4'h0, 4'h0);
    expectXfer(2'd0, 4'h0, 4'h0);
    expectXfer(2'd1, 4'h0, 4'h0);
    waitXfer("t3_ch3", cyc);
    waitXfer("t3_ch0", cyc);
    waitXfer("t3_ch1b", cyc);
    bus.dreq = 4'h0;
    tick();

    // Block mode ch0, terminal count on the third word.
    applyStimulus(8'h80, 8'h80, 4'h0, 4'h0, 4'b0001);
    expectXfer(2'd0, 4'h0, 4'h0);
    expectXfer(2'd0, 4'h0, 4'h0);
    expectXfer(2'd0, 4'b0001, 4'b0001);
    waitXfer("t4_w1", cyc);
    waitXfer("t4_w2", cyc);
    checkOutput("t4_spacing", 32'(cyc), 32'd3);
    checkOutput("t4_no_adstb", 32'({bus.adstb, bus.rd_strobe}), 32'b01);
    tick();
    bus.tc = 1'b1;
    waitXfer("t4_w3", cyc);
    checkOutput("t4_hrq_drop", 32'(bus.hrq), 32'd0);
    bus.tc   = 1'b0;
    bus.dreq = 4'h0;
    tick();

    // HLDA lost in S3 must not disturb the rotating pointer.
    applyReset();
    autoHlda = 1'b1;
    applyStimulus(8'h10, 8'h40, 4'h0, 4'h0, 4'b0001);
    startSeen = xferSeen;
    cyc = 0;
    while (!bus.wr_strobe && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput("t5_reach_s3", 32'(bus.wr_strobe), 32'd1);
    autoHlda = 1'b0;
    bus.hlda = 1'b0;
    bus.dreq = 4'h0;
    tick();
    checkOutput("t5_abort", 32'({bus.hrq, bus.aen, bus.dack}), 32'({2'b00, 4'hF}));
    tick();
    checkOutput("t5_no_xfer", 32'(xferSeen - startSeen), 32'd0);
    bus.dreq = 4'b0011;
    autoHlda = 1'b1;
    expectXfer(2'd0, 4'h0, 4'h0);
    waitXfer("t5_resume", cyc);
    bus.dreq = 4'h0;
    tick();

    // Demand mode ch3: request withdrawn during the second word.
    applyStimulus(8'h80, 8'h00, 4'h0, 4'h0, 4'b1000);
    startSeen = xferSeen;
    expectXfer(2'd3, 4'h0, 4'h0);
    expectXfer(2'd3, 4'h0, 4'h0);
    waitXfer("t6_w1", cyc);
    tick();
    bus.dreq = 4'h0;
    waitXfer("t6_w2", cyc);
    checkOutput("t6_idle", 32'(bus.hrq), 32'd0);
    repeat (5) tick();
    checkOutput("t6_count", 32'(xferSeen - startSeen), 32'd2);

    // Software request overrides the mask; EOP terminates it.
    applyStimulus(8'h80, 8'h40, 4'b1000, 4'b1000, 4'b1000);
    bus.eop_n = 1'b0;
    expectXfer(2'd3, 4'b1000, 4'b1000);
    waitXfer("t6_soft", cyc);
    applyStimulus(8'h80, 8'h40, 4'h0, 4'h0, 4'h0);
    bus.eop_n = 1'b1;
    tick();

    // Active-low DREQ: only the line driven low requests.
    applyStimulus(8'hC0, 8'h40, 4'h0, 4'h0, 4'b1011);
    expectXfer(2'd2, 4'h0, 4'h0);
    waitXfer("t7_dreq_low", cyc);
    bus.dreq = 4'hF;
    tick();

    // Reset pulled in the middle of S2.
    applyStimulus(8'h00, 8'h40, 4'h0, 4'h0, 4'b0001);
    cyc = 0;
    while (!bus.rd_strobe && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput("t8_reach_s2", 32'(bus.rd_strobe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t8_async_reset",
                32'({bus.hrq, bus.aen, bus.rd_strobe, bus.xfer_strobe, bus.active_ch, bus.dack}),
                32'({4'b0000, 2'd0, 4'hF}));
    autoHlda = 1'b0;
    bus.hlda = 1'b0;
    bus.dreq = 4'h0;
    tick();

    // Controller disabled: requests never raise HRQ.
    applyStimulus(8'h04, 8'h40, 4'h0, 4'h0, 4'hF);
    rst_n    = 1'b1;
    hrqCount = 0;
    repeat (10) begin
      tick();
      if (bus.hrq) hrqCount++;
    end
    checkOutput("t9_disabled_hrq", 32'(hrqCount), 32'd0);

    checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
